// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote,
// parity/framing checks, break lockout and a first-word fall-through receive FIFO.
module uart_rx_param #(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD       = 230400,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 rd_en,
    output logic                 rd_valid,
    output logic [DATA_BITS-1:0] rd_data,
    output logic                 rd_perr,
    output logic                 rd_ferr,
    output logic                 overflow,
    output logic                 busy
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int MID          = (CLKS_PER_BIT - 1) / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = $clog2(DATA_BITS);
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int EW           = DATA_BITS + 2;

    localparam logic [CW-1:0] CNT_MID  = CW'(MID);
    localparam logic [CW-1:0] CNT_S1   = CW'(CLKS_PER_BIT - 3);
    localparam logic [CW-1:0] CNT_S2   = CW'(CLKS_PER_BIT - 2);
    localparam logic [CW-1:0] CNT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    localparam logic [2:0] IDLE_S  = 3'd0;
    localparam logic [2:0] START_S = 3'd1;
    localparam logic [2:0] DATA_S  = 3'd2;
    localparam logic [2:0] PAR_S   = 3'd3;
    localparam logic [2:0] STOP_S  = 3'd4;

    logic                 sync_q, rs_q;
    logic [2:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 armed_q, armed_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 s1_q, s1_d, s2_q, s2_d;
    logic                 vote, push;
    logic [EW-1:0]        push_entry;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                 overflow_q, overflow_d;
    logic                 empty, full, pop, wr_en;

    // NOTE: every clocked block uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q     <= 1'b1;
            rs_q       <= 1'b1;
            state_q    <= IDLE_S;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            armed_q    <= 1'b0;
            shreg_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync_q     <= rxd;
            rs_q       <= sync_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            armed_q    <= armed_d;
            shreg_q    <= shreg_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: each signal gets a default first, so no path leaves it unassigned and no latch appears.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        armed_d    = armed_q;
        shreg_d    = shreg_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        push       = 1'b0;
        vote       = (s1_q & s2_q) | (s1_q & rs_q) | (s2_q & rs_q);

        if (state_q != IDLE_S) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_S1) s1_d = rs_q;
            if (cnt_q == CNT_S2) s2_d = rs_q;
        end

        case (state_q)
            IDLE_S: begin
                cnt_d = '0;
                if (rs_q) armed_d = 1'b1;
                else if (armed_q) state_d = START_S;
            end
            START_S: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d = '0;
                    if (!rs_q) begin
                        state_d   = DATA_S;
                        bit_idx_d = '0;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                    end else begin
                        state_d = IDLE_S;
                    end
                end
            end
            DATA_S: begin
                if (cnt_q == CNT_END) begin
                    cnt_d              = '0;
                    shreg_d[bit_idx_q] = vote;
                    if (bit_idx_q == BIT_LAST) begin
                        bit_idx_d  = '0;
                        stop_idx_d = 1'b0;
                        state_d    = (PARITY != 0) ? PAR_S : STOP_S;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            PAR_S: begin
                if (cnt_q == CNT_END) begin
                    cnt_d   = '0;
                    perr_d  = (^shreg_q ^ vote) != (PARITY == 1);
                    state_d = STOP_S;
                end
            end
            STOP_S: begin
                if (cnt_q == CNT_END) begin
                    cnt_d = '0;
                    if (!vote) ferr_d = 1'b1;
                    if (STOP_BITS == 1 || stop_idx_q) begin
                        push    = 1'b1;
                        state_d = IDLE_S;
                        // A low stop bit may be a held break: wait for the line to go high.
                        if (ferr_d) armed_d = 1'b0;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    assign push_entry = {ferr_d, perr_q, shreg_q};

    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = rd_en && !empty;
        wr_en      = push && (!full || pop);
        wr_ptr_d   = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = push && full && !pop;
    end

    // NOTE: storage has no reset; outputs are gated by empty, so stale contents never show.
    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
    end

    assign {rd_ferr, rd_perr, rd_data} = empty ? {EW{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];
    assign rd_valid = !empty;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE_S);
endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: an 8N1 receiver and a 7E1 receiver, both at 217 clocks per bit.
module tb_uart_rx_param;
    localparam int CLK_FREQ = 100_000_000;
    localparam int BAUD     = 460_800;
    localparam int CPB      = 217;
    localparam int MID      = 108;

    logic       clock;
    logic       reset;
    logic       rxd_a, rxd_b, rd_en_a, rd_en_b;
    logic       rd_valid_a, rd_perr_a, rd_ferr_a, overflow_a, busy_a;
    logic       rd_valid_b, rd_perr_b, rd_ferr_b, overflow_b, busy_b;
    logic [7:0] rd_data_a;
    logic [6:0] rd_data_b;

    int n_cmp = 0;
    int n_mis = 0;
    int ovf_cnt = 0;
    int ovf_base;

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) u_dut_a (
        .clock(clock), .reset(reset), .rxd(rxd_a), .rd_en(rd_en_a),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_perr(rd_perr_a),
        .rd_ferr(rd_ferr_a), .overflow(overflow_a), .busy(busy_a)
    );

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(2)) u_dut_b (
        .clock(clock), .reset(reset), .rxd(rxd_b), .rd_en(rd_en_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_perr(rd_perr_b),
        .rd_ferr(rd_ferr_b), .overflow(overflow_b), .busy(busy_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) if (overflow_a === 1'b1) ovf_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] frame8(input logic [7:0] d);
        return {2'b11, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [11:0] frame7(input logic [6:0] d, input logic p);
        return {2'b11, 1'b1, p, d, 1'b0};
    endfunction

    task automatic drive(input bit sel, input logic v);
        if (sel) rxd_b = v;
        else     rxd_a = v;
    endtask

    // Sends bits[0..9]; optional 1-cycle low glitch at the last vote sample of
    // bit gl_bit, optional pop of DUT a on the edge that pushes this frame.
    task automatic send(input bit sel, input logic [11:0] bits, input int gl_bit, input bit pop_last);
        for (int i = 0; i < 10; i++) begin
            drive(sel, bits[i]);
            if (i == gl_bit) begin
                repeat (MID + 1) @(negedge clock);
                drive(sel, 1'b0);
                @(negedge clock);
                drive(sel, bits[i]);
                repeat (CPB - MID - 2) @(negedge clock);
            end else if (pop_last && i == 9) begin
                repeat (MID + 3) @(negedge clock);
                rd_en_a = 1'b1;
                @(negedge clock);
                rd_en_a = 1'b0;
                repeat (CPB - MID - 4) @(negedge clock);
            end else begin
                repeat (CPB) @(negedge clock);
            end
        end
    endtask

    task automatic pop_check(input bit sel, input string tag, input logic [7:0] d,
                             input logic pe, input logic fe);
        if (sel) begin
            check({tag, ".valid"}, 32'(rd_valid_b), 32'd1);
            check({tag, ".data"},  32'(rd_data_b),  32'(d));
            check({tag, ".perr"},  32'(rd_perr_b),  32'(pe));
            check({tag, ".ferr"},  32'(rd_ferr_b),  32'(fe));
            rd_en_b = 1'b1;
        end else begin
            check({tag, ".valid"}, 32'(rd_valid_a), 32'd1);
            check({tag, ".data"},  32'(rd_data_a),  32'(d));
            check({tag, ".perr"},  32'(rd_perr_a),  32'(pe));
            check({tag, ".ferr"},  32'(rd_ferr_a),  32'(fe));
            rd_en_a = 1'b1;
        end
        @(negedge clock);
        rd_en_a = 1'b0;
        rd_en_b = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rxd_a = 1'b1; rxd_b = 1'b1; rd_en_a = 1'b0; rd_en_b = 1'b0;
        repeat (3) @(negedge clock);
        check("rst.valid",    32'(rd_valid_a), 32'd0);
        check("rst.data",     32'(rd_data_a),  32'd0);
        check("rst.perr",     32'(rd_perr_a),  32'd0);
        check("rst.ferr",     32'(rd_ferr_a),  32'd0);
        check("rst.overflow", 32'(overflow_a), 32'd0);
        check("rst.busy",     32'(busy_a),     32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clock);

        // Back-to-back 8N1 frames
        send(1'b0, frame8(8'h55), -1, 1'b0);
        send(1'b0, frame8(8'hA3), -1, 1'b0);
        pop_check(1'b0, "basic0", 8'h55, 1'b0, 1'b0);
        pop_check(1'b0, "basic1", 8'hA3, 1'b0, 1'b0);
        check("basic.empty", 32'(rd_valid_a), 32'd0);

        // 7E1: 0x41 has two ones, so the correct even parity bit is 0
        send(1'b1, frame7(7'h41, 1'b1), -1, 1'b0);
        pop_check(1'b1, "par_bad", 8'h41, 1'b1, 1'b0);
        send(1'b1, frame7(7'h41, 1'b0), -1, 1'b0);
        pop_check(1'b1, "par_ok", 8'h41, 1'b0, 1'b0);
        check("par.empty", 32'(rd_valid_b), 32'd0);

        // Held break: one errored frame, then normal reception after release
        rxd_a = 1'b0;
        repeat (20 * CPB) @(negedge clock);
        rxd_a = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        pop_check(1'b0, "break", 8'h00, 1'b0, 1'b1);
        check("break.single", 32'(rd_valid_a), 32'd0);
        send(1'b0, frame8(8'h12), -1, 1'b0);
        pop_check(1'b0, "after_break", 8'h12, 1'b0, 1'b0);
        check("after_break.empty", 32'(rd_valid_a), 32'd0);

        // 100-cycle low pulse is shorter than the start-bit centre
        rxd_a = 1'b0;
        repeat (50) @(negedge clock);
        check("glitch.busy_hi", 32'(busy_a), 32'd1);
        repeat (50) @(negedge clock);
        rxd_a = 1'b1;
        repeat (CPB) @(negedge clock);
        check("glitch.busy_lo", 32'(busy_a), 32'd0);
        check("glitch.no_entry", 32'(rd_valid_a), 32'd0);
        send(1'b0, frame8(8'hFF), 4, 1'b0);
        pop_check(1'b0, "vote", 8'hFF, 1'b0, 1'b0);

        // Overflow on the fifth unread frame
        ovf_base = ovf_cnt;
        for (int i = 1; i <= 4; i++) send(1'b0, frame8(8'(i)), -1, 1'b0);
        check("ovf.none_yet", 32'(ovf_cnt - ovf_base), 32'd0);
        send(1'b0, frame8(8'h05), -1, 1'b0);
        check("ovf.one_pulse", 32'(ovf_cnt - ovf_base), 32'd1);
        for (int i = 1; i <= 4; i++) pop_check(1'b0, "ovf_rd", 8'(i), 1'b0, 1'b0);
        check("ovf.empty", 32'(rd_valid_a), 32'd0);

        // Reset in the middle of DATA clears the FIFO and the partial frame
        send(1'b0, frame8(8'h77), -1, 1'b0);
        check("rstmid.stored", 32'(rd_valid_a), 32'd1);
        rxd_a = 1'b0;
        repeat (3 * CPB) @(negedge clock);
        check("rstmid.busy", 32'(busy_a), 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid.valid", 32'(rd_valid_a), 32'd0);
        check("rstmid.data",  32'(rd_data_a),  32'd0);
        check("rstmid.busy0", 32'(busy_a),     32'd0);
        rxd_a = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (12 * CPB) @(negedge clock);
        check("rstmid.no_entry", 32'(rd_valid_a), 32'd0);
        check("rstmid.idle",     32'(busy_a),     32'd0);

        // Full FIFO with a pop on the push edge: no overflow, still four entries
        ovf_base = ovf_cnt;
        for (int i = 0; i < 4; i++) send(1'b0, frame8(8'(8'h10 + i)), -1, 1'b0);
        send(1'b0, frame8(8'h14), -1, 1'b1);
        check("simul.no_ovf", 32'(ovf_cnt - ovf_base), 32'd0);
        for (int i = 1; i <= 4; i++) pop_check(1'b0, "simul_rd", 8'(8'h10 + i), 1'b0, 1'b0);
        check("simul.empty", 32'(rd_valid_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver with a small receive FIFO, the synthesizable successor to the team's fixed 8N1 behavioural receiver used in simulation to capture the SoC's `uart_rtl_0_txd` output. It adds configurable data width, parity and stop bits, an input synchroniser, 3-sample majority voting, error flags and overflow detection. It sits between the UART pin and any consumer: a bench monitor or an on-chip host/DMA path.

## Interface
- `CLK_FREQ`, 100000000: clock frequency in Hz.
- `BAUD`, 230400: line rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` uses integer division; the default gives 434. Requires `CLKS_PER_BIT >= 8`.
- `DATA_BITS`, 8: data bits per frame, legal range 5..9, sent LSB first.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clock`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rxd`  in  1  serial line, asynchronous, idle high.
- `rd_en`  in  1  pop request for the FIFO head.
- `rd_valid`  out  1  FIFO not empty (first-word fall-through).
- `rd_data`  out  DATA_BITS  data field of the FIFO head.
- `rd_perr`  out  1  parity-error flag of the head entry.
- `rd_ferr`  out  1  framing-error flag of the head entry.
- `overflow`  out  1  one-cycle pulse when a completed frame is dropped.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Synchroniser:** `rxd` passes through two flops, both reset to 1. Every FSM decision uses the synchronised bit `rs`.
- **Timer:** `cnt` is reset to 0 on each state entry and after each bit centre. `MID = (CLKS_PER_BIT-1)/2`.
- **Majority vote:** in DATA, PARITY and STOP, the samples of `rs` at `cnt = CLKS_PER_BIT-3` and `cnt = CLKS_PER_BIT-2` are registered. At `cnt = CLKS_PER_BIT-1` the bit value is the majority of those two samples and the current `rs`.
- **States:**
  - IDLE: `armed` is set while `rs = 1`. If `armed` and `rs = 0`, go to START with `cnt = 0`.
  - START: at `cnt = MID`, if `rs = 0` go to DATA with `cnt = 0`; otherwise this was a glitch, return to IDLE.
  - DATA: shift the voted bit into `shreg[bit_idx]`. After `DATA_BITS` bits, go to PARITY if `PARITY != 0`, else to STOP.
  - PARITY: `perr = (^data ^ pbit) != (PARITY == 1)`. For odd parity the total count of ones must be odd; for even parity it must be even. Then go to STOP.
  - STOP: sample `STOP_BITS` bits. `ferr` is set if any stop bit votes 0. At the last stop-bit centre, push the entry {ferr, perr, data} and go to IDLE.
- **Break handling:** when entering IDLE with `ferr = 1`, `armed` is cleared. No new start bit is accepted until `rs` has been seen high, so a held-low break line produces one frame, not a stream of frames.
- **FIFO:**
  - Entry width is `DATA_BITS + 2`. Pointers are `log2(FIFO_DEPTH)+1` bits and wrap naturally.
  - A pop occurs when `rd_en & rd_valid`. `rd_en` while empty is ignored.
  - A push into a full FIFO is dropped, contents are unchanged and `overflow` pulses.
  - A push and a pop in the same cycle when full: both take effect, with no overflow.
  - A push and a pop in the same cycle when the FIFO holds one entry: the head advances to the new entry and `rd_valid` stays high.
- **Errored frames:** frames with errors are still stored, with their flags set.

## Timing
- **Reset values (asynchronous, immediate):** state IDLE, `armed = 0`, `cnt = 0`, FIFO empty. Outputs: `rd_valid = 0`, `rd_data = 0`, `rd_perr = 0`, `rd_ferr = 0`, `overflow = 0`, `busy = 0`.
- **Reset mid-frame:** the partial frame is discarded and the FIFO is cleared.
- **Line to FSM:** 2 cycles from `rxd` falling to `rs` falling. START is entered on the following edge.
- **Start timing:** the start bit is confirmed `MID+1` cycles after START entry.
- **Bit timing:** each subsequent bit lasts exactly `CLKS_PER_BIT` cycles.
- **Push latency:** the push occurs on the clock edge at the last stop-bit centre. `rd_valid` and the head outputs update on that same edge, so they are visible the cycle after the centre.
- **Overflow:** `overflow` is high for exactly the one cycle following the dropped push.
- **Pop:** a pop updates `rd_data`, `rd_perr` and `rd_ferr` to the next entry on the next edge. `rd_valid` falls on that edge if the popped entry was the last.
- **Frame spacing:** IDLE accepts a new start bit on the cycle immediately after the push, so back-to-back frames with zero idle time are received.

## Test plan
- **Basic 8N1:** defaults; send 0x55, then 0xA3, with no inter-frame gap -> two entries, `rd_data` 0x55 then 0xA3, `rd_perr = rd_ferr = 0`.
- **Parity:** `PARITY = 2`, `DATA_BITS = 7`; send 0x41 with parity bit 1 (wrong) -> `rd_data` 0x41, `rd_perr = 1`. Repeat with parity bit 0 -> `rd_perr = 0`.
- **Framing and break:** hold `rxd` low for 20 bit times -> exactly one entry, data 0x00 with `rd_ferr = 1`. Release the line, then send 0x12 -> one more entry, 0x12 with no errors.
- **Glitch rejection:** a 100-cycle low pulse on the idle line -> no entry, `busy` returns low. A 1-cycle low glitch at the centre of bit 3 of 0xFF -> `rd_data` 0xFF.
- **Overflow:** with `FIFO_DEPTH = 4`, send 0x01..0x05 with no reads -> one `overflow` pulse on frame 5. Reads return 0x01..0x04, then `rd_valid = 0`.
- **Reset and simultaneous push/pop:** assert `reset` in the middle of DATA -> no entry and outputs return to reset values. With the FIFO full, assert `rd_en` on the push cycle -> no overflow and the count stays at 4.
